sensor_frame_tx: RTL and testbench
==================================

Name: sensor_frame_tx

Overview:
- Encodes and serialises 11-byte sensor frames over a UART line, as the transmit-side counterpart of the sensor frame parser.
- Frame layout: header 0x55, type, 8 payload bytes, checksum.
- Used as an on-board sensor emulator for loopback testing, and to drive the wireless module's RX pin.
- Accepts one frame per valid/ready handshake, then shifts it out 8N1, LSB first.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. BIT_CYCLES = CLK_FREQ/BAUD (integer division) must be ≥ 2.
- GAP_BITS, 10, idle bit-times inserted after each frame. Used only when SENSOR_TX_GAP_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- send_valid  in  1  frame request.
- send_ready  out  1  block can accept a frame.
- send_type  in  8  frame type byte (e.g. 0x51 acceleration, 0x53 angle).
- send_data  in  64  payload as four 16-bit words. Word k is bits [16k+15:16k]. Each word is sent little-endian.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress; equals ~send_ready.

Behaviour:
- Reset values: tx=1, send_ready=1, busy=0, byte index 0, checksum 0, bit counter 0.
- Reset asserted mid-frame forces tx=1 immediately and discards the frame. After reset releases, the block is idle with no partial retransmission.
- Handshake:
  - A frame is accepted on a rising edge where send_valid & send_ready; send_type and send_data are captured at that edge.
  - send_ready drops the following cycle and stays low until the frame (and gap, if enabled) completes.
  - send_valid is ignored while send_ready=0. Inputs need only be stable at the accepting edge.
- Byte sequence, index 0..10: 0x55, type, d[7:0], d[15:8], d[23:16], ..., d[63:56], checksum.
- Checksum = 8-bit sum of bytes 0..9, modulo 256 with carries discarded. It is accumulated as bytes are loaded and sent as byte 10.
- States:
  - IDLE: send_ready=1, tx=1. On handshake, go to LOAD.
  - LOAD: select the byte for the current index and add it to the checksum (except index 10). Pulse start to the sub-module. Go to SEND.
  - SEND: wait for the sub-module's done pulse. Then: if index==10, go to GAP (if enabled) or IDLE; else increment index and go to LOAD.
  - GAP: hold tx=1 for GAP_BITS*BIT_CYCLES cycles, then go to IDLE.
- Timing:
  - The header start bit (tx=0) begins 2 cycles after the accepting edge.
  - Each bit lasts exactly BIT_CYCLES cycles. A character is 10 bits: start, 8 data LSB-first, stop.
  - Consecutive characters are separated by exactly one LOAD cycle plus the handshake overhead (≤ 2 cycles). No extra idle bits.
  - send_ready returns high ≤ 2 cycles after the checksum stop bit ends (no-gap build).
- A handshake in the same cycle as the final done pulse is not possible, because ready is low. Back-to-back frames are accepted on the first IDLE cycle.

Optional Feature:
- Macro: SENSOR_TX_GAP_EN.
- Defined: the GAP state is present. After every frame, tx is held idle high for GAP_BITS*BIT_CYCLES cycles before send_ready rises. This guarantees resynchronisation margin for the receiver.
- Undefined: no GAP state and no gap counter; the block returns from SEND directly to IDLE.

Decomposition:
- Package sensor_pkg holds:
  - HEADER = 8'h55, MESSAGE_LENGTH = 11, ACCELERATION_TYPE = 8'h51, DIRECTION_TYPE = 8'h53.
  - Typedef enum for state {IDLE, LOAD, SEND, GAP}.
  - Typedef sensor_payload_t, a packed array of four 16-bit words.
- One sub-module, async_transmitter, matching the existing async_receiver:
  - Ports: clk, rst, start, data[7:0], tx, done.
  - Parameters: CLK_FREQ, BAUD.
  - Behaviour: one-cycle done pulse at the end of the stop bit.
- Top level holds the frame FSM, byte mux and checksum.

Test Plan:
- Acceleration frame: BIT_CYCLES=434, type 0x51, data 64'h0000_0000_0000_1234 -> decoded bytes 55 51 34 12 00 00 00 00 00 00 EC. Each bit is 434 cycles; start bit begins 2 cycles after handshake.
- Checksum wrap: type 0x53, data all 0xFF -> bytes 55 53 FF×8, checksum 0xA0.
- Loopback: tx into the sensor parser, type 0x53, data 64'h0000_0000_ABCD_0000 -> parser direction becomes 0xABCD after the checksum byte; acceleration unchanged.
- Handshake: hold send_valid high with changing data during a frame -> only the first value is sent. A second frame starts on the first cycle send_ready=1, with no bytes lost or duplicated.
- Reset mid-frame: assert rst during byte 4 -> tx=1 in the same cycle, send_ready=1 after release. The next frame is clean and the parser accepts it.
- SENSOR_TX_GAP_EN, GAP_BITS=10: back-to-back frames -> exactly 4340 idle-high cycles (±2) between the checksum stop bit and the next header start bit.

Source files
------------

// File: rtl/sensor_pkg.sv
// sensor_pkg: shared constants and types for the sensor frame transmitter.
//   HEADER / MESSAGE_LENGTH / frame type codes, the frame FSM state type and
//   the payload type (four 16-bit words, word k = bits [16k+15:16k]).
// Optional feature macro: SENSOR_TX_GAP_EN adds the GAP state.
package sensor_pkg;

    localparam logic [7:0]  HEADER            = 8'h55;
    localparam int unsigned MESSAGE_LENGTH    = 11;
    localparam logic [7:0]  ACCELERATION_TYPE = 8'h51;
    localparam logic [7:0]  DIRECTION_TYPE    = 8'h53;

    typedef logic [3:0][15:0] sensor_payload_t;

`ifdef SENSOR_TX_GAP_EN
    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif

    // Payload byte n (0..7): words go out in order, each little-endian.
    function automatic logic [7:0] payload_byte(sensor_payload_t p, logic [2:0] n);
        return n[0] ? p[n[2:1]][15:8] : p[n[2:1]][7:0];
    endfunction

endpackage

// File: rtl/sensor_frame_tx_if.sv
// sensor_frame_tx_if: frame request handshake.
//   send_valid  frame request (master -> slave)
//   send_ready  slave can accept a frame (slave -> master)
//   send_type   frame type byte
//   send_data   64-bit payload, four 16-bit words
interface sensor_frame_tx_if;
    import sensor_pkg::*;

    logic            send_valid;
    logic            send_ready;
    logic [7:0]      send_type;
    sensor_payload_t send_data;

    modport master (output send_valid, output send_type, output send_data, input send_ready);
    modport slave  (input send_valid, input send_type, input send_data, output send_ready);
endinterface

// File: rtl/async_transmitter.sv
// async_transmitter: 8N1 UART transmitter, LSB first.
//   clk, rst  clock, asynchronous active-high reset
//   start     one-cycle request, honoured only while idle; data captured with it
//   data      byte to send
//   tx        serial line, idle high (registered)
//   done      one-cycle pulse at the end of the stop bit
module async_transmitter #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int unsigned CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

    logic          active;
    logic [CW-1:0] cyc;
    logic [3:0]    bit_idx;   // 0 = start bit, 1..8 = data, 9 = stop bit
    logic [8:0]    shreg;     // remaining data bits with the stop bit behind them

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            cyc     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active  <= 1'b1;
                    cyc     <= '0;
                    bit_idx <= '0;
                    shreg   <= {1'b1, data};
                    tx      <= 1'b0;
                end
            end else if (cyc == CW'(BIT_CYCLES - 1)) begin
                cyc <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                cyc <= cyc + CW'(1);
            end
        end
    end
endmodule

// File: rtl/sensor_frame_tx.sv
// sensor_frame_tx: encodes and serialises 11-byte sensor frames
//   (0x55, type, 8 payload bytes, checksum) over an 8N1 UART line.
//   clk, rst  clock, asynchronous active-high reset
//   send      sensor_frame_tx_if slave: send_valid/send_ready/send_type/send_data
//   tx        serial line, idle high
//   busy      frame in progress, equals ~send_ready
// Optional feature macro: SENSOR_TX_GAP_EN (GAP_BITS idle bit-times after each frame).
module sensor_frame_tx
    import sensor_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
`ifdef SENSOR_TX_GAP_EN
    ,
    parameter int unsigned GAP_BITS = 10
`endif
) (
    input  logic                clk,
    input  logic                rst,
    sensor_frame_tx_if.slave    send,
    output logic                tx,
    output logic                busy
);
    localparam logic [3:0] LAST_IDX = 4'(MESSAGE_LENGTH - 1);

`ifdef SENSOR_TX_GAP_EN
    localparam int unsigned GAP_CYCLES = GAP_BITS * (CLK_FREQ / BAUD);
    localparam int unsigned GW         = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    logic [GW-1:0] gap_cnt;
`endif

    state_t          state;
    logic [3:0]      idx;
    logic [7:0]      csum;
    logic [7:0]      type_q;
    sensor_payload_t data_q;
    logic [7:0]      byte_q;
    logic [7:0]      cur_byte;
    logic            start;
    logic            ready_q;
    logic            done;

    always_comb begin
        cur_byte = csum;
        if (idx == 4'd0) begin
            cur_byte = HEADER;
        end else if (idx == 4'd1) begin
            cur_byte = type_q;
        end else if (idx != LAST_IDX) begin
            cur_byte = payload_byte(data_q, 3'(idx - 4'd2));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            csum    <= '0;
            type_q  <= '0;
            data_q  <= '0;
            byte_q  <= '0;
            start   <= 1'b0;
            ready_q <= 1'b1;
`ifdef SENSOR_TX_GAP_EN
            gap_cnt <= '0;
`endif
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (send.send_valid && ready_q) begin
                        type_q  <= send.send_type;
                        data_q  <= send.send_data;
                        idx     <= '0;
                        csum    <= '0;
                        ready_q <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    byte_q <= cur_byte;
                    start  <= 1'b1;
                    if (idx != LAST_IDX) begin
                        csum <= csum + cur_byte;
                    end
                    state <= SEND;
                end
                SEND: begin
                    if (done) begin
                        if (idx == LAST_IDX) begin
`ifdef SENSOR_TX_GAP_EN
                            gap_cnt <= '0;
                            state   <= GAP;
`else
                            ready_q <= 1'b1;
                            state   <= IDLE;
`endif
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= LOAD;
                        end
                    end
                end
`ifdef SENSOR_TX_GAP_EN
                // Two cycles short: the SEND->GAP and IDLE->LOAD->start overhead
                // makes up the rest of the idle time seen on the line.
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 3)) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
`endif
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    async_transmitter #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (byte_q),
        .tx    (tx),
        .done  (done)
    );

    assign send.send_ready = ready_q;
    assign busy            = ~ready_q;
endmodule

// File: tb/tb_sensor_frame_tx.sv
`timescale 1ns/1ps
module tb_sensor_frame_tx;
    import sensor_pkg::*;

    localparam int unsigned CLK_FREQ = 80;
    localparam int unsigned BAUD     = 10;
    localparam int          BC       = 8;     // cycles per bit
`ifdef SENSOR_TX_GAP_EN
    localparam int unsigned GAP_BITS = 10;
    localparam int          EXTRA    = GAP_BITS * BC - 2;
`else
    localparam int          EXTRA    = 0;
`endif

    typedef logic [7:0] frame_t [11];
    typedef int stamps_t [11];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   accept_cyc = 0;
    logic [15:0] par_acc = 16'h0000;
    logic [15:0] par_dir = 16'h0000;

    sensor_frame_tx_if bus ();

`ifdef SENSOR_TX_GAP_EN
    sensor_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .GAP_BITS(GAP_BITS)) dut (
        .clk(clk), .rst(rst), .send(bus), .tx(tx), .busy(busy));
`else
    sensor_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst(rst), .send(bus), .tx(tx), .busy(busy));
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver: call at a negedge; samples each bit in its middle.
    task automatic rx_byte(output logic [7:0] b, output int start_cyc, output bit ok);
        int   waited = 0;
        logic st;
        b = '0; ok = 1'b0; start_cyc = 0;
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            n_cmp++; n_fail++;
            $display("FAIL rx_timeout: tx=%b, required a start bit within 400 cycles", tx);
            return;
        end
        start_cyc = cyc;
        repeat (BC / 2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (BC) @(negedge clk);
            b[i] = tx;
        end
        repeat (BC) @(negedge clk);
        ok = (st === 1'b0) && (tx === 1'b1);
    endtask

    task automatic rx_frame(output frame_t f, output stamps_t s, output bit ok);
        bit bok;
        ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            rx_byte(f[i], s[i], bok);
            if (!bok) ok = 1'b0;
        end
    endtask

    // Parser model: accepts a frame with a good header and checksum.
    task automatic parse(input frame_t f);
        logic [7:0] sum = 8'h00;
        for (int i = 0; i < 10; i++) sum = sum + f[i];
        if (f[0] == 8'h55 && sum == f[10]) begin
            if (f[1] == 8'h51) par_acc = {f[3], f[2]};
            if (f[1] == 8'h53) par_dir = {f[5], f[4]};
        end
    endtask

    task automatic start_frame(input logic [7:0] t, input logic [63:0] d, input bit drop);
        int w = 0;
        @(negedge clk);
        while (bus.send_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (bus.send_ready !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL ready_timeout: send_ready=%b, required 1", bus.send_ready);
        end
        bus.send_valid = 1'b1;
        bus.send_type  = t;
        bus.send_data  = d;
        @(negedge clk);
        accept_cyc = cyc;
        if (drop) bus.send_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (bus.send_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", bus.send_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_accel();
        frame_t f, e;
        stamps_t s;
        bit ok;
        e = '{8'h55, 8'h51, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEC};
        start_frame(8'h51, 64'h0000_0000_0000_1234, 1'b1);
        n_cmp++; if (bus.send_ready !== 1'b0) begin
            n_fail++; $display("FAIL accel_ready_low: got %b want 0", bus.send_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL accel_busy: got %b want 1", busy); end
        rx_frame(f, s, ok);
        for (int i = 0; i < 11; i++) begin
            n_cmp++; if (f[i] !== e[i]) begin
                n_fail++; $display("FAIL accel_byte%0d: got %h want %h", i, f[i], e[i]); end
        end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL accel_framing: got %b want 1", ok); end
        n_cmp++; if (s[0] - accept_cyc !== 2) begin
            n_fail++; $display("FAIL accel_latency: got %0d want 2", s[0] - accept_cyc); end
        n_cmp++; if (s[1] - s[0] !== 10 * BC + 3) begin
            n_fail++; $display("FAIL accel_char_spacing: got %0d want %0d", s[1] - s[0], 10 * BC + 3); end
        while (cyc < s[10] + 10 * BC + EXTRA) @(negedge clk);
        n_cmp++; if (bus.send_ready !== 1'b0) begin
            n_fail++; $display("FAIL accel_ready_early: got %b want 0", bus.send_ready); end
        @(negedge clk);
        n_cmp++; if (bus.send_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL accel_ready_return: got ready=%b busy=%b want 1/0",
                               bus.send_ready, busy); end
        parse(f);
    endtask

    task automatic test_wrap();
        frame_t f, e;
        stamps_t s;
        bit ok;
        e = '{8'h55, 8'h53, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA0};
        start_frame(8'h53, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        rx_frame(f, s, ok);
        for (int i = 0; i < 11; i++) begin
            n_cmp++; if (f[i] !== e[i]) begin
                n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, f[i], e[i]); end
        end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_framing: got %b want 1", ok); end
        parse(f);
    endtask

    task automatic test_loopback();
        frame_t f;
        stamps_t s;
        bit ok;
        start_frame(8'h53, 64'h0000_0000_ABCD_0000, 1'b1);
        rx_frame(f, s, ok);
        n_cmp++; if (f[10] !== 8'h20) begin
            n_fail++; $display("FAIL loop_checksum: got %h want 20", f[10]); end
        parse(f);
        n_cmp++; if (par_dir !== 16'hABCD) begin
            n_fail++; $display("FAIL loop_direction: got %h want abcd", par_dir); end
        n_cmp++; if (par_acc !== 16'h1234) begin
            n_fail++; $display("FAIL loop_accel_kept: got %h want 1234", par_acc); end
    endtask

    task automatic test_back_to_back();
        frame_t f1, f2, e1, e2;
        stamps_t s1, s2;
        bit ok1, ok2;
        e1 = '{8'h55, 8'h51, 8'h44, 8'h44, 8'h33, 8'h33, 8'h22, 8'h22, 8'h11, 8'h11, 8'hFA};
        e2 = '{8'h55, 8'h53, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hCC};
        start_frame(8'h51, 64'h1111_2222_3333_4444, 1'b0);
        // valid stays high with new contents; they must wait for the next frame
        bus.send_type = 8'h53;
        bus.send_data = 64'h0102_0304_0506_0708;
        rx_frame(f1, s1, ok1);
        fork
            rx_frame(f2, s2, ok2);
            begin
                int w = 0;
                while (bus.send_ready !== 1'b1 && w < 400) begin @(negedge clk); w++; end
                w = 0;
                while (bus.send_ready !== 1'b0 && w < 10) begin @(negedge clk); w++; end
                bus.send_valid = 1'b0;
            end
        join
        for (int i = 0; i < 11; i++) begin
            n_cmp++; if (f1[i] !== e1[i]) begin
                n_fail++; $display("FAIL b2b_first_byte%0d: got %h want %h", i, f1[i], e1[i]); end
            n_cmp++; if (f2[i] !== e2[i]) begin
                n_fail++; $display("FAIL b2b_second_byte%0d: got %h want %h", i, f2[i], e2[i]); end
        end
        n_cmp++; if (ok1 !== 1'b1 || ok2 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_framing: got %b%b want 11", ok1, ok2); end
        n_cmp++; if (s2[0] - s1[10] !== 10 * BC + 4 + EXTRA) begin
            n_fail++; $display("FAIL b2b_frame_gap: got %0d want %0d", s2[0] - s1[10],
                               10 * BC + 4 + EXTRA); end
        // no third frame may follow
        repeat (EXTRA + 20) @(negedge clk);
        n_cmp++; if (bus.send_ready !== 1'b1 || tx !== 1'b1) begin
            n_fail++; $display("FAIL b2b_no_extra: got ready=%b tx=%b want 1/1", bus.send_ready, tx); end
    endtask

    task automatic test_reset_mid_frame();
        frame_t f, e;
        stamps_t s;
        bit ok;
        logic [7:0] b;
        int sc, w, lows;
        e = '{8'h55, 8'h53, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5C};
        start_frame(8'h51, 64'h0000_0000_0000_1234, 1'b1);
        for (int i = 0; i < 4; i++) rx_byte(b, sc, ok);
        w = 0;
        while (tx !== 1'b0 && w < 400) begin @(negedge clk); w++; end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        n_cmp++; if (bus.send_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ready: got ready=%b busy=%b want 1/0",
                               bus.send_ready, busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.send_ready !== 1'b1) lows++;
        end
        n_cmp++; if (lows !== 0) begin
            n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", lows); end
        start_frame(8'h53, 64'h0000_0000_5A5A_0000, 1'b1);
        rx_frame(f, s, ok);
        for (int i = 0; i < 11; i++) begin
            n_cmp++; if (f[i] !== e[i]) begin
                n_fail++; $display("FAIL rstmid_byte%0d: got %h want %h", i, f[i], e[i]); end
        end
        parse(f);
        n_cmp++; if (par_dir !== 16'h5A5A) begin
            n_fail++; $display("FAIL rstmid_parser: got %h want 5a5a", par_dir); end
    endtask

    initial begin
        bus.send_valid = 1'b0;
        bus.send_type  = 8'h00;
        bus.send_data  = '0;
        test_reset();
        test_accel();
        test_wrap();
        test_loopback();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
